// File: rtl/patbuf_write_arb.sv
// Write-side arbiter for the pattern buffer: fixed-priority core writes over a bursting bulk loader.
// Optional macro PATBUF_LIVE_LOCK_EN adds live_buf/live_lock to stall bursts into the buffer in use.
module patbuf_write_arb #(
   parameter int unsigned BUFFER_SIZE  = 22,
   parameter int unsigned BUFFER_WIDTH = 8,
   parameter int unsigned NO_BUFS      = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cpu_req,
   input  logic [2:0]              cpu_buf,
   input  logic [4:0]              cpu_field,
   input  logic [BUFFER_WIDTH-1:0] cpu_data,
   output logic                    cpu_ack,
   input  logic                    ld_start,
   input  logic [2:0]              ld_buf,
   input  logic [4:0]              ld_first,
   input  logic [4:0]              ld_count,
   input  logic                    ld_valid,
   input  logic [BUFFER_WIDTH-1:0] ld_data,
   output logic                    ld_ready,
   output logic                    ld_busy,
   output logic                    ld_done,
   output logic                    ld_err,
   output logic [2:0]              bufp_out,
   output logic [BUFFER_SIZE-1:0]  fieldwp_out,
   output logic [BUFFER_WIDTH-1:0] field_in_out,
   output logic                    field_write_out
`ifdef PATBUF_LIVE_LOCK_EN
   ,
   input  logic [2:0]              live_buf,
   input  logic [0:0]              live_lock
`endif
);

   typedef enum logic {S_IDLE, S_LOAD} state_t;

   localparam logic [BUFFER_SIZE-1:0] FIELD_ONE = BUFFER_SIZE'(1);

   state_t                  state, state_nxt;
   logic [2:0]              lbuf, lbuf_nxt;
   logic [4:0]              ptr, ptr_nxt;
   logic [4:0]              rem, rem_nxt;
   logic                    err_nxt, done_nxt;
   logic                    beat;
   logic                    ld_stall;
   logic                    cpu_ok;
   logic                    ld_bad;
   logic                    wr_en;
   logic [2:0]              wr_buf;
   logic [4:0]              wr_field;
   logic [BUFFER_WIDTH-1:0] wr_data;

`ifdef PATBUF_LIVE_LOCK_EN
   assign ld_stall = live_lock[0] && (lbuf == live_buf);
`else
   assign ld_stall = 1'b0;
`endif

   assign cpu_ok = ({27'd0, cpu_field} < BUFFER_SIZE) && ({29'd0, cpu_buf} < NO_BUFS);

   // Range check done at 6 bits so first+count cannot wrap and slip past the limit.
   assign ld_bad = (ld_count == 5'd0)
                || (({1'b0, ld_first} + {1'b0, ld_count}) > 6'(BUFFER_SIZE))
                || ({29'd0, ld_buf} >= NO_BUFS);

   always_comb begin
      state_nxt = state;
      lbuf_nxt  = lbuf;
      ptr_nxt   = ptr;
      rem_nxt   = rem;
      err_nxt   = 1'b0;
      done_nxt  = 1'b0;
      beat      = 1'b0;
      ld_ready  = 1'b0;
      ld_busy   = (state == S_LOAD);
      wr_en     = 1'b0;
      wr_buf    = cpu_buf;
      wr_field  = cpu_field;
      wr_data   = cpu_data;

      case (state)
         S_IDLE: begin
            if (ld_start) begin
               if (ld_bad) begin
                  err_nxt = 1'b1;
               end else begin
                  lbuf_nxt  = ld_buf;
                  ptr_nxt   = ld_first;
                  rem_nxt   = ld_count;
                  state_nxt = S_LOAD;
               end
            end
         end
         S_LOAD: begin
            ld_ready = !cpu_req && !ld_stall;
            beat     = ld_valid && ld_ready;
            if (beat) begin
               ptr_nxt = ptr + 5'd1;
               rem_nxt = rem - 5'd1;
               if (rem == 5'd1) begin
                  done_nxt  = 1'b1;
                  state_nxt = S_IDLE;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase

      // Core request always owns the port; an out-of-range core request still blocks the loader.
      if (cpu_req) begin
         wr_en = cpu_ok;
      end else if (beat) begin
         wr_en    = 1'b1;
         wr_buf   = lbuf;
         wr_field = ptr;
         wr_data  = ld_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= S_IDLE;
         lbuf            <= '0;
         ptr             <= '0;
         rem             <= '0;
         cpu_ack         <= 1'b0;
         ld_done         <= 1'b0;
         ld_err          <= 1'b0;
         bufp_out        <= '0;
         fieldwp_out     <= '0;
         field_in_out    <= '0;
         field_write_out <= 1'b0;
      end else begin
         state           <= state_nxt;
         lbuf            <= lbuf_nxt;
         ptr             <= ptr_nxt;
         rem             <= rem_nxt;
         cpu_ack         <= cpu_req;
         ld_done         <= done_nxt;
         ld_err          <= err_nxt;
         field_write_out <= wr_en;
         fieldwp_out     <= wr_en ? (FIELD_ONE << wr_field) : '0;
         if (wr_en) begin
            bufp_out     <= wr_buf;
            field_in_out <= wr_data;
         end
      end
   end

endmodule

// File: doc/patbuf_write_arb.md
Name: patbuf_write_arb

Overview:
- Write-side controller for the pattern buffer store.
- Arbitrates two requesters onto the single field-write port (bufp, one-hot fieldwp, field_in, field_write):
  - the pat core issuing single-field writes;
  - a bulk loader streaming a contiguous run of fields into one buffer.
- Sits between the pat core / host load path and the pattern buffer field-write inputs.
- Core has fixed priority; the loader is sequenced by a burst FSM.

Parameters:
- BUFFER_SIZE, 22, fields per buffer (one-hot fieldwp width).
- BUFFER_WIDTH, 8, field data width.
- NO_BUFS, 8, number of buffers (bufp range 0..NO_BUFS-1).

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- cpu_req  input  1  single-field write request, level; held until cpu_ack.
- cpu_buf  input  3  target buffer.
- cpu_field  input  5  target field index.
- cpu_data  input  BUFFER_WIDTH  write data.
- cpu_ack  output  1  one-cycle pulse, request consumed.
- ld_start  input  1  burst start pulse, sampled in IDLE only.
- ld_buf  input  3  burst target buffer.
- ld_first  input  5  first field index.
- ld_count  input  5  number of fields, 1..BUFFER_SIZE.
- ld_valid  input  1  burst data valid.
- ld_data  input  BUFFER_WIDTH  burst data.
- ld_ready  output  1  burst data accepted when ld_valid & ld_ready.
- ld_busy  output  1  FSM in LOAD.
- ld_done  output  1  one-cycle pulse, last burst field written.
- ld_err  output  1  one-cycle pulse, burst rejected.
- bufp_out  output  3  to pattern buffer bufp_in.
- fieldwp_out  output  BUFFER_SIZE  one-hot write field pointer.
- field_in_out  output  BUFFER_WIDTH  write data.
- field_write_out  output  1  write strobe.

Behaviour:
- Reset values: all outputs 0, FSM IDLE, internal pointer and remaining count 0.
- States:
  - IDLE: ld_start is checked.
    - If ld_count==0, or ld_first+ld_count>BUFFER_SIZE (6-bit compare), or ld_buf>=NO_BUFS: ld_err pulses the next cycle and the FSM stays in IDLE.
    - Otherwise: latch buf, ptr=ld_first, rem=ld_count; go to LOAD.
  - LOAD: ld_busy=1. ld_ready = !cpu_req (combinational).
    - On a beat (ld_valid & ld_ready): issue a write at ptr, ptr+1, rem-1.
    - When rem==1 on the beat: go to IDLE; ld_done pulses in the same cycle as that final field_write_out.
- Arbitration, evaluated every cycle in any state:
  - cpu_req wins and ld_ready is forced low that cycle.
  - At most one write is issued per cycle.
  - cpu_ack is registered and pulses the cycle after acceptance.
  - The requester must drop cpu_req on cpu_ack or a second write occurs. Back-to-back acceptance is allowed.
- Write latency: acceptance at cycle N puts the write on the outputs at N+1.
  - field_write_out=1 for exactly one cycle.
  - fieldwp_out has bit[field] set.
  - field_in_out carries the data; bufp_out carries the buffer.
- Idle outputs: field_write_out=0, fieldwp_out=0, field_in_out holds its last value, bufp_out holds its last value.
- Core writes with cpu_field>=BUFFER_SIZE or cpu_buf>=NO_BUFS: cpu_ack still pulses, no write is issued.
- ld_start in LOAD is ignored, with no error.
- No field wrap-around: the range check makes ptr never exceed BUFFER_SIZE-1.
- rst mid-burst: immediate return to IDLE, with no ld_done and no ld_err. A write staged at the rst edge is dropped.
- Simultaneous cpu_req and final burst beat: the core write goes first, and the burst beat waits.

Optional Feature:
- PATBUF_LIVE_LOCK_EN: adds inputs live_buf[2:0] and live_lock[0:0].
- With the macro defined: in LOAD, while live_lock=1 and the latched burst buffer==live_buf, ld_ready=0.
  - Loader beats stall; FSM state, ptr and rem are held.
  - Core writes are unaffected.
  - A new ld_start targeting live_buf while live_lock=1 is accepted and stalls from its first beat.
- Without the macro: the ports are absent and ld_ready = !cpu_req in LOAD.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0, ld_busy=0.
- ld_start buf=3 first=4 count=3, ld_valid held high with data A1,A2,A3 ->
  - three consecutive writes: bufp_out=3, fieldwp_out bits 4,5,6, data A1..A3;
  - ld_done coincides with the third strobe;
  - ld_busy is 0 the next cycle.
- Mid-burst cpu_req buf=1 field=21 data=5A, held until ack ->
  - ld_ready low that cycle;
  - write bufp_out=1, fieldwp_out=bit21, data=5A; cpu_ack pulses;
  - burst then resumes at the correct next field with no lost or duplicated beat.
- ld_start first=20 count=3 -> ld_err pulses once, ld_busy stays 0, no field_write_out.
- rst asserted after 2 of 5 burst beats -> IDLE next cycle, no ld_done, no further writes.
- PATBUF_LIVE_LOCK_EN: live_lock=1, live_buf=3, burst to buf 3 ->
  - ld_ready stays 0, and a concurrent core write to buf 3 field 0 still completes;
  - dropping live_lock lets the burst complete.
